huff_bit_packer: RTL and testbench
==================================

Name: huff_bit_packer

Overview:
- Sits directly downstream of the Huffman encoder top. Consumes its serial code stream: one bit per cycle while out_valid/out_code are high.
- Packs each frame (all code bits of one encoded word) MSB-first into bytes, padding the final partial byte with zeros.
- Buffers the bytes in a small FIFO and presents them on a valid/ready byte interface with an end-of-frame marker and a frame bit count.
- The upstream encoder cannot be stalled, so buffer overflow is flagged rather than back-pressured.

Parameters:
- FIFO_DEPTH, 4: number of byte entries in the output FIFO (power of 2, ≥2).
- LEN_W, 6: width of the frame bit counter. Maximum frame is 5 chars × 7 bits = 35.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  code bit valid (encoder out_valid)
- in_bit  in  1  code bit (encoder out_code)
- out_ready  in  1  downstream accepts byte
- out_valid  out  1  FIFO head valid
- out_data  out  8  FIFO head byte; first received bit in bit 7
- out_last  out  1  head byte is final byte of frame
- frame_done  out  1  one-cycle pulse, frame fully queued
- frame_bits  out  LEN_W  bit count of last completed frame; held until next frame_done
- ovf  out  1  sticky: a byte was dropped or a bit arrived outside COLLECT

Behaviour:
- Reset (async): FSM→IDLE, FIFO empty.
  - Outputs: out_valid=0, out_data=0, out_last=0, frame_done=0, frame_bits=0, ovf=0.
  - Cleared: shift register, bit counter, pend_valid.
  - Reset mid-frame discards all buffered data.
- FSM states: IDLE, COLLECT, FLUSH_PEND, FLUSH_PART.
  - IDLE --in_valid--> COLLECT. The bit arriving on that cycle is captured as the frame's first bit. Frame counter is set to 1.
  - COLLECT: each in_valid cycle shifts in_bit into an 8-bit shift register at the LSB end. frame counter +1, sub-bit counter (3 bits) +1.
  - Byte completion: on the 8th bit, the shift register contents plus that bit move to staging register pend and pend_valid is set. The sub-counter wraps to 0.
  - pend is pushed to the FIFO with last=0 on the next in_valid cycle, in the same cycle as that bit's shift.
  - COLLECT --!in_valid--> FLUSH_PEND. The first low cycle ends the frame; gaps inside a frame are not supported.
  - FLUSH_PEND: if pend_valid, push pend with last = (sub-counter==0). Clear pend_valid. → FLUSH_PART.
  - FLUSH_PART: if sub-counter≠0, push {shift bits, zero pad} left-aligned with last=1.
    - Pad example: 3 bits b2b1b0 → {b2,b1,b0,00000}.
  - FLUSH_PART also pulses frame_done, loads frame_bits ← frame counter, clears counters, → IDLE.
- FIFO:
  - out_valid = !empty.
  - out_data/out_last are driven from the head entry, registered storage with a combinational read of the head.
  - Pop on out_valid && out_ready.
  - Push+pop in the same cycle is legal when full (count unchanged).
  - Push when full without a pop: the byte is dropped and ovf is set.
- in_valid high during FLUSH_PEND/FLUSH_PART: the bit is ignored and ovf is set. The upstream guarantees a gap of ≥9 cycles between frames, so this indicates a protocol error.
- ovf clears only on reset.
- frame_done is a registered pulse one cycle after FLUSH_PART. Latency from the last bit to frame_done: 3 cycles.
- frame counter saturates at 2^LEN_W−1; no wrap.
- out_data/out_last values are don't-care when out_valid=0. The bench checks them only with valid.

Test Plan:
- out_ready=1, 4-bit frame 1,0,1,1 → one byte 0xB0, out_last=1; frame_bits=4; frame_done 3 cycles after last bit.
- out_ready=1, 16-bit frame 0xA5 then 0x3C (MSB first) → bytes 0xA5 (last=0), 0x3C (last=1); frame_bits=16; no padding byte emitted.
- out_ready=0, 35-bit frame → bytes 1–4 queued, partial 3-bit byte dropped, ovf=1.
  - Then raise out_ready: 4 bytes drain, 4th has last=0.
- FIFO_DEPTH=4, out_ready toggled 1/0 every cycle, 35-bit frame "ILOVE" code → 5 bytes in order, 5th last=1 with pad zeros, ovf=0.
- rst_n pulsed low after 10 bits of a frame → all outputs 0 immediately.
  - A following 7-bit frame 1111111 → single byte 0xFE, last=1, frame_bits=7.
- in_valid reasserted the cycle after a frame ends → ovf=1, extra bit absent from output; the previous frame is still emitted intact.

Source files
------------

// File: rtl/huff_bit_packer.sv
// Packs the serial Huffman code stream into MSB-first bytes,
// queues them in a small FIFO and flags overflow (no back-pressure).
module huff_bit_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             frame_done,
    output logic [LEN_W-1:0] frame_bits,
    output logic             ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_FLUSH_PEND,
        S_FLUSH_PART
    } state_t;

    state_t           r_state;
    logic [7:0]       r_shift;
    logic [7:0]       r_pend;
    logic             r_pend_valid;
    logic [2:0]       r_sub;
    logic [LEN_W-1:0] r_cnt;
    logic             r_frame_done;
    logic [LEN_W-1:0] r_frame_bits;
    logic             r_ovf_proto;

    logic [8:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_ovf_drop;

    logic             w_push;
    logic [7:0]       w_pdata;
    logic             w_plast;
    logic [7:0]       w_pad;
    logic             w_full;
    logic             w_pop;
    logic             w_wr;
    logic [8:0]       w_head;

    // Partial byte: the r_sub received bits moved up to bit 7, zeros below.
    assign w_pad  = r_shift << (4'd8 - {1'b0, r_sub});
    assign w_full = (r_count == DEPTH_C);
    assign w_pop  = (r_count != '0) && out_ready;
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_head = r_mem[r_rptr];

    assign out_valid  = (r_count != '0);
    assign out_data   = out_valid ? w_head[7:0] : 8'h00;
    assign out_last   = out_valid ? w_head[8] : 1'b0;
    assign frame_done = r_frame_done;
    assign frame_bits = r_frame_bits;
    assign ovf        = r_ovf_proto | r_ovf_drop;

    // Select which byte (if any) the framer hands to the FIFO this cycle.
    always_comb begin
        w_push  = 1'b0;
        w_pdata = r_pend;
        w_plast = 1'b0;
        unique case (r_state)
            S_COLLECT: begin
                w_push = in_valid && r_pend_valid;
            end
            S_FLUSH_PEND: begin
                w_push  = r_pend_valid;
                w_plast = (r_sub == 3'd0);
            end
            S_FLUSH_PART: begin
                w_push  = (r_sub != 3'd0);
                w_pdata = w_pad;
                w_plast = 1'b1;
            end
            default: begin
                w_push = 1'b0;
            end
        endcase
    end

    // Frame FSM: collect bits, stage full bytes, flush tail, report length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_sub        <= '0;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
            r_frame_bits <= '0;
            r_ovf_proto  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shift <= {7'd0, in_bit};
                        r_sub   <= 3'd1;
                        r_cnt   <= {{(LEN_W-1){1'b0}}, 1'b1};
                        r_state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (in_valid) begin
                        if (r_pend_valid) begin
                            r_pend_valid <= 1'b0;
                        end
                        r_shift <= {r_shift[6:0], in_bit};
                        if (r_sub == 3'd7) begin
                            r_pend       <= {r_shift[6:0], in_bit};
                            r_pend_valid <= 1'b1;
                        end
                        r_sub <= r_sub + 3'd1;
                        if (r_cnt != '1) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_state <= S_FLUSH_PEND;
                    end
                end
                S_FLUSH_PEND: begin
                    if (in_valid) begin
                        r_ovf_proto <= 1'b1;
                    end
                    r_pend_valid <= 1'b0;
                    r_state      <= S_FLUSH_PART;
                end
                S_FLUSH_PART: begin
                    if (in_valid) begin
                        r_ovf_proto <= 1'b1;
                    end
                    r_frame_done <= 1'b1;
                    r_frame_bits <= r_cnt;
                    r_cnt        <= '0;
                    r_sub        <= '0;
                    r_shift      <= '0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte FIFO: drop-and-flag on push into a full queue with no pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ovf_drop <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= {w_plast, w_pdata};
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push && !w_wr) begin
                r_ovf_drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_huff_bit_packer.sv
// Randomized bench for huff_bit_packer against a byte-list model
// built directly from the frame bits.
module tb_huff_bit_packer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_done;
    logic [5:0] frame_bits;
    logic       ovf;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_edge = 0;
    int got_base = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    logic [5:0] done_bits = '0;
    logic [8:0] got[$];
    logic [8:0] exp_q[$];

    huff_bit_packer #(.FIFO_DEPTH(4), .LEN_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_done(frame_done),
        .frame_bits(frame_bits),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got.push_back({out_last, out_data});
        if (rst_n && frame_done) begin
            done_cyc  = cyc;
            done_cnt  = done_cnt + 1;
            done_bits = frame_bits;
        end
    end

    task automatic do_reset();
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got_base = got.size();
    endtask

    task automatic send_frame(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_bit   = v[n-1-i];
        end
        @(posedge clk);
        #1;
        last_edge = cyc;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
    endtask

    // Expected bytes: bit k of the frame lands in byte k/8 at position 7-(k%8).
    task automatic build_exp(input logic [63:0] v, input int n);
        int nb;
        logic [7:0] b;
        exp_q.delete();
        nb = (n + 7) / 8;
        for (int k = 0; k < nb; k++) begin
            b = 8'h00;
            for (int j = 0; j < 8; j++) begin
                if (8*k + j < n) b[7-j] = v[n-1-(8*k+j)];
            end
            exp_q.push_back({(k == nb-1), b});
        end
    endtask

    task automatic wait_drain(input int n, output bit to);
        to = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (got.size() - got_base >= n && !out_valid) begin
                to = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", out_last); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
        checks++;
        if (frame_bits !== 6'd0) begin errors++; $display("FAIL reset_bits: got %0d want 0", frame_bits); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_small();
        bit to;
        do_reset();
        out_ready = 1'b1;
        build_exp(64'hB, 4);
        send_frame(64'hB, 4);
        wait_drain(1, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL small_timeout: got 1 want 0"); end
        checks++;
        if (got.size() - got_base !== 1) begin errors++; $display("FAIL small_count: got %0d want 1", got.size() - got_base); end
        checks++;
        if (got.size() > got_base && got[got_base] !== 9'h1B0) begin errors++; $display("FAIL small_byte: got %h want 1b0", got[got_base]); end
        checks++;
        if (exp_q[0] !== 9'h1B0) begin errors++; $display("FAIL small_model: got %h want 1b0", exp_q[0]); end
        checks++;
        if (done_bits !== 6'd4) begin errors++; $display("FAIL small_bits: got %0d want 4", done_bits); end
        checks++;
        if (done_cyc - last_edge !== 3) begin errors++; $display("FAIL small_latency: got %0d want 3", done_cyc - last_edge); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL small_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_two_bytes();
        bit to;
        do_reset();
        out_ready = 1'b1;
        build_exp(64'hA53C, 16);
        send_frame(64'hA53C, 16);
        wait_drain(2, to);
        checks++;
        if (got.size() - got_base !== 2) begin errors++; $display("FAIL two_count: got %0d want 2", got.size() - got_base); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_base + i < got.size() && got[got_base+i] !== exp_q[i]) begin
                errors++; $display("FAIL two_byte%0d: got %h want %h", i, got[got_base+i], exp_q[i]);
            end
        end
        checks++;
        if (done_bits !== 6'd16) begin errors++; $display("FAIL two_bits: got %0d want 16", done_bits); end
        checks++;
        if (done_cyc - last_edge !== 3) begin errors++; $display("FAIL two_latency: got %0d want 3", done_cyc - last_edge); end
    endtask

    task automatic test_overflow();
        bit to;
        logic [63:0] v;
        do_reset();
        v = {$urandom, $urandom};
        build_exp(v, 35);
        send_frame(v, 35);
        repeat (8) @(negedge clk);
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        checks++;
        if (done_bits !== 6'd35) begin errors++; $display("FAIL ovf_bits: got %0d want 35", done_bits); end
        out_ready = 1'b1;
        wait_drain(4, to);
        checks++;
        if (got.size() - got_base !== 4) begin errors++; $display("FAIL ovf_count: got %0d want 4", got.size() - got_base); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_base + i < got.size() && got[got_base+i] !== {1'b0, exp_q[i][7:0]}) begin
                errors++; $display("FAIL ovf_byte%0d: got %h want %h", i, got[got_base+i], {1'b0, exp_q[i][7:0]});
            end
        end
    endtask

    task automatic test_toggle();
        bit to;
        logic [63:0] v;
        do_reset();
        v = {$urandom, $urandom};
        build_exp(v, 35);
        fork
            send_frame(v, 35);
            begin
                for (int c = 0; c < 80; c++) begin
                    @(posedge clk);
                    #1;
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        wait_drain(5, to);
        checks++;
        if (got.size() - got_base !== 5) begin errors++; $display("FAIL tog_count: got %0d want 5", got.size() - got_base); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_base + i < got.size() && got[got_base+i] !== exp_q[i]) begin
                errors++; $display("FAIL tog_byte%0d: got %h want %h", i, got[got_base+i], exp_q[i]);
            end
        end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL tog_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_reset_mid();
        bit to;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_bit   = 1'($urandom);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_last, frame_done, frame_bits, ovf} !== 18'd0) begin
            errors++; $display("FAIL mid_reset_outs: got %b%h%b%b%0d%b want all zero", out_valid, out_data, out_last, frame_done, frame_bits, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got_base = got.size();
        send_frame(64'h7F, 7);
        wait_drain(1, to);
        checks++;
        if (got.size() - got_base !== 1) begin errors++; $display("FAIL mid_count: got %0d want 1", got.size() - got_base); end
        checks++;
        if (got.size() > got_base && got[got_base] !== 9'h1FE) begin errors++; $display("FAIL mid_byte: got %h want 1fe", got[got_base]); end
        checks++;
        if (done_bits !== 6'd7) begin errors++; $display("FAIL mid_bits: got %0d want 7", done_bits); end
    endtask

    task automatic test_extra_bit();
        bit to;
        int d0;
        logic [63:0] v;
        do_reset();
        out_ready = 1'b1;
        d0 = done_cnt;
        v = {32'd0, $urandom};
        build_exp(v, 20);
        send_frame(v, 20);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        wait_drain(3, to);
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL extra_ovf: got %b want 1", ovf); end
        checks++;
        if (got.size() - got_base !== 3) begin errors++; $display("FAIL extra_count: got %0d want 3", got.size() - got_base); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_base + i < got.size() && got[got_base+i] !== exp_q[i]) begin
                errors++; $display("FAIL extra_byte%0d: got %h want %h", i, got[got_base+i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL extra_frames: got %0d want 1", done_cnt - d0); end
        checks++;
        if (done_bits !== 6'd20) begin errors++; $display("FAIL extra_bits: got %0d want 20", done_bits); end
    endtask

    task automatic test_random();
        bit to;
        int n;
        logic [63:0] v;
        do_reset();
        out_ready = 1'b1;
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(35, 1);
            v = {$urandom, $urandom};
            build_exp(v, n);
            got_base = got.size();
            send_frame(v, n);
            wait_drain(exp_q.size(), to);
            checks++;
            if (got.size() - got_base !== exp_q.size()) begin
                errors++; $display("FAIL rnd%0d_count: got %0d want %0d", f, got.size() - got_base, exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_base + i < got.size() && got[got_base+i] !== exp_q[i]) begin
                    errors++; $display("FAIL rnd%0d_byte%0d: got %h want %h", f, i, got[got_base+i], exp_q[i]);
                end
            end
            checks++;
            if (done_bits !== 6'(n)) begin errors++; $display("FAIL rnd%0d_bits: got %0d want %0d", f, done_bits, n); end
            repeat (10) @(negedge clk);
        end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL rnd_ovf: got %b want 0", ovf); end
    endtask

    initial begin
        test_reset();
        test_small();
        test_two_bytes();
        test_overflow();
        test_toggle();
        test_reset_mid();
        test_extra_bit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
